// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the instruction fetch address, resolves
// branch/jump/exception redirects and hands accepted instructions to decode.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        exc,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] epc
);

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic [31:0] epc_next;

    logic [31:0] seq_target;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic [31:0] jr_target;
    logic [31:0] redirect_target;
    logic        active;
    logic        redirect;

    // Candidate targets, all relative to the pc currently being fetched.
    assign seq_target    = pc + 32'd4;
    assign branch_target = seq_target + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_addr     = {seq_target[31:28], jump_target, 2'b00};
    assign jr_target     = {jr_addr[31:2], 2'b00};

    // Redirect inputs only matter while a fetch is in flight; BOOT ignores them.
    assign active   = (state == FETCH) || (state == FLUSH);
    assign redirect = active && (exc || jr || jump || branch_taken);

    always_comb begin
        redirect_target = seq_target;
        if (exc)
            redirect_target = EXC_VECTOR;
        else if (jr)
            redirect_target = jr_target;
        else if (jump)
            redirect_target = jump_addr;
        else if (branch_taken)
            redirect_target = branch_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= BOOT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (!imem_ready && redirect) state_next = FLUSH;
            FLUSH:   if (imem_ready) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req    = active;
        imem_addr   = pc;
        fetch_pc    = pc;
        fetch_valid = (state == FETCH) && imem_ready && !redirect && !stall;
    end

    // A redirect that arrives while memory is busy is parked in pending and
    // applied when the outstanding (discarded) response finally returns.
    always_comb begin
        pc_next      = pc;
        pending_next = pending;
        epc_next     = epc;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect)
                        pc_next = redirect_target;
                    else if (!stall)
                        pc_next = seq_target;
                end else if (redirect) begin
                    pending_next = redirect_target;
                end
            end
            FLUSH: begin
                if (imem_ready)
                    pc_next = redirect ? redirect_target : pending;
                else if (redirect)
                    pending_next = redirect_target;
            end
            default: ;
        endcase
        if (active && exc)
            epc_next = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_VECTOR;
            pending <= 32'h0;
            epc     <= 32'h0;
        end else begin
            pc      <= pc_next;
            pending <= pending_next;
            epc     <= epc_next;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-002 EXC_VECTOR, 32'h8000_0180, PC value loaded on exception.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  decode cannot accept an instruction this cycle.
REQ-006 branch_taken  input  1  conditional branch resolved taken.
REQ-007 branch_imm  input  16  signed word offset for the branch.
REQ-008 jump  input  1  absolute jump (J/JAL).
REQ-009 jump_target  input  26  word index for the jump.
REQ-010 jr  input  1  register jump (JR/JALR).
REQ-011 jr_addr  input  32  register jump address.
REQ-012 exc  input  1  exception request.
REQ-013 imem_ready  input  1  instruction memory completes the current request.
REQ-014 imem_req  output  1  fetch request valid.
REQ-015 imem_addr  output  32  fetch address, equal to the internal pc register.
REQ-016 fetch_valid  output  1  one-cycle strobe: the fetched instruction is accepted.
REQ-017 fetch_pc  output  32  address of the accepted instruction.
REQ-018 epc  output  32  pc value captured at the last exception.

Function
REQ-019 The block SHALL hold a 32-bit pc register and a 4-state FSM: BOOT, FETCH, FLUSH, and HALT, where HALT is unreachable and SHALL return to BOOT.
REQ-020 In BOOT, the block SHALL drive imem_req=0 and fetch_valid=0, ignore all redirect inputs, and go to FETCH on the next edge.
REQ-021 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc.
REQ-022 The redirect target SHALL be selected in priority order exc > jr > jump > branch_taken; with none asserted, it SHALL be the sequential target.
REQ-023 Sequential target SHALL be pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-024 Branch target SHALL be pc+4+(sign_extend(branch_imm)<<2), modulo 2^32.
REQ-025 Jump target SHALL be {(pc+4)[31:28], jump_target, 2'b00}.
REQ-026 JR target SHALL be {jr_addr[31:2], 2'b00}.
REQ-027 Exception target SHALL be EXC_VECTOR, and epc SHALL load pc on the same edge.
REQ-028 FETCH with imem_ready=1, no redirect, and stall=0: fetch_valid=1 and fetch_pc=pc combinationally; pc<=pc+4; stay in FETCH.
REQ-029 FETCH with imem_ready=1, no redirect, and stall=1: fetch_valid=0; pc unchanged; stay in FETCH, so the instruction is refetched.
REQ-030 FETCH with imem_ready=1 and a redirect: fetch_valid=0, regardless of stall; pc<=redirect target; stay in FETCH.
REQ-031 FETCH with imem_ready=0 and a redirect: the target SHALL be stored in a pending register, and the state SHALL go to FLUSH.
REQ-032 In FLUSH, the block SHALL hold imem_req=1 and imem_addr=pc until imem_ready=1; the returned instruction SHALL be discarded (fetch_valid=0).
REQ-033 A new redirect in FLUSH SHALL overwrite the pending target; same-cycle redirects resolve by REQ-022.
REQ-034 An exc in FLUSH SHALL capture the current pc into epc.
REQ-035 FLUSH with imem_ready=1: pc<=pending target (or the same-cycle redirect target, if one is asserted); go to FETCH.
REQ-036 A redirect SHALL always take precedence over stall.
REQ-037 fetch_valid SHALL never be asserted in BOOT or FLUSH, nor in two consecutive cycles with the same fetch_pc.

Reset
REQ-038 While rst=1, asynchronously: pc=RESET_VECTOR, state=BOOT, pending target=0, epc=0, imem_req=0, fetch_valid=0, fetch_pc=0.
REQ-039 Assertion of rst in any state, including FLUSH with a request outstanding, SHALL abandon all state; the outstanding memory response SHALL be ignored.
REQ-040 The first imem_req after reset release SHALL occur one cycle after BOOT, with imem_addr=RESET_VECTOR.

Verification
REQ-041 Release rst, imem_ready=1 constantly, no redirects -> fetch_valid pulses every cycle with fetch_pc 0, 4, 8, 12.
REQ-042 At pc=0x40: stall=1 for 3 cycles, imem_ready=1 -> fetch_valid=0 for 3 cycles and imem_addr held at 0x40; then fetch_pc=0x40.
REQ-043 At pc=0x100: branch_taken=1, branch_imm=16'hFFFE, imem_ready=1 -> fetch_valid=0 and next imem_addr=0xFC; with jump=1 and jump_target=26'h10 in the same cycle, next imem_addr=0x40 instead.
REQ-044 At pc=0x200: imem_ready=0 and jr=1 with jr_addr=0x1003 -> FLUSH, imem_addr stays 0x200; ready after 2 cycles -> no fetch_valid; next imem_addr=0x1000.
REQ-045 In FLUSH at pc=0x300: exc=1 -> epc=0x300, and after imem_ready the next imem_addr=0x8000_0180.
REQ-046 Sequential fetch at pc=0xFFFF_FFFC with stall=0 -> next imem_addr=0; rst pulse mid-FLUSH -> imem_req=0 immediately, then BOOT and imem_addr=0.
